// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle data-memory port onto a valid/ready system bus.
// Stalls the core for the bus round trip and returns extended load data plus an mcause code.
module data_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned EXC_LD_MISAL   = 4,
    parameter int unsigned EXC_LD_FAULT   = 5,
    parameter int unsigned EXC_ST_MISAL   = 6,
    parameter int unsigned EXC_ST_FAULT   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  inst_type_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] read_data_o,
    output logic [31:0] exception_o,
    output logic        stall_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_strb_o,
    input  logic        bus_rvalid_i,
    input  logic        bus_rerr_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} stateT;

    stateT           state;
    logic [CntW-1:0] cycleCnt;
    logic [1:0]      lowAddr;
    logic [1:0]      sizeReg;
    logic            unsReg;
    logic            loadReg;
    logic [31:0]     doneExc;

    logic        isLoad, isStore, validAccess, misaligned, launch, timedOut;
    logic [1:0]  size;
    logic [3:0]  strbNext;
    logic [31:0] wdataNext;
    logic [31:0] rdataShift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] loadExt;
    logic [31:0] faultCode;

    assign isLoad      = inst_type_i[3];
    assign isStore     = inst_type_i[2];
    assign size        = inst_type_i[1:0];
    assign validAccess = (isLoad ^ isStore) && (size != 2'b11);
    assign misaligned  = ((size == 2'b01) && addr_i[0]) ||
                         ((size == 2'b10) && (addr_i[1:0] != 2'b00));
    assign launch      = validAccess && !misaligned;
    assign timedOut    = cycleCnt >= CntLast;
    assign faultCode   = loadReg ? 32'(EXC_LD_FAULT) : 32'(EXC_ST_FAULT);

    always_comb begin
        strbNext  = 4'b1111;
        wdataNext = wdata_i;
        case (size)
            2'b00: begin
                strbNext  = 4'b0001 << addr_i[1:0];
                wdataNext = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                strbNext  = 4'b0011 << addr_i[1:0];
                wdataNext = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign rdataShift = bus_rdata_i >> {lowAddr, 3'b000};
    assign rbyte      = rdataShift[7:0];
    assign rhalf      = lowAddr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        loadExt = bus_rdata_i;
        case (sizeReg)
            2'b00:   loadExt = {{24{~unsReg & rbyte[7]}}, rbyte};
            2'b01:   loadExt = {{16{~unsReg & rhalf[15]}}, rhalf};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cycleCnt    <= '0;
            lowAddr     <= '0;
            sizeReg     <= '0;
            unsReg      <= 1'b0;
            loadReg     <= 1'b0;
            doneExc     <= '0;
            read_data_o <= '0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_strb_o  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (launch) begin
                        state       <= StReq;
                        cycleCnt    <= '0;
                        lowAddr     <= addr_i[1:0];
                        sizeReg     <= size;
                        unsReg      <= unsigned_i;
                        loadReg     <= isLoad;
                        bus_valid_o <= 1'b1;
                        bus_we_o    <= isStore;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_wdata_o <= isStore ? wdataNext : 32'd0;
                        bus_strb_o  <= isStore ? strbNext : 4'b0000;
                    end
                end
                StReq: begin
                    cycleCnt <= cycleCnt + CntW'(1);
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        state       <= StResp;
                    end else if (timedOut) begin
                        // Abandon the unaccepted request; the only legal withdrawal.
                        bus_valid_o <= 1'b0;
                        doneExc     <= faultCode;
                        read_data_o <= '0;
                        state       <= StDone;
                    end
                end
                StResp: begin
                    cycleCnt <= cycleCnt + CntW'(1);
                    if (bus_rvalid_i) begin
                        read_data_o <= loadReg ? loadExt : 32'd0;
                        doneExc     <= bus_rerr_i ? faultCode : 32'd0;
                        state       <= StDone;
                    end else if (timedOut) begin
                        doneExc     <= faultCode;
                        read_data_o <= '0;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    read_data_o <= '0;
                    doneExc     <= '0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        stall_o     = rst_n && ((state == StIdle && launch) || state == StReq ||
                                state == StResp);
        exception_o = '0;
        if (rst_n) begin
            if (state == StDone) begin
                exception_o = doneExc;
            end else if (state == StIdle && validAccess && misaligned) begin
                exception_o = isLoad ? 32'(EXC_LD_MISAL) : 32'(EXC_ST_MISAL);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed table-driven bench for data_mem_bridge with hand sequences for
// timeout and mid-transaction reset.
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  instType;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [31:0] readData, exc;
    logic        stall, busValid, busReady, busWe, busRvalid, busRerr;
    logic [31:0] busAddr, busWdata, busRdata;
    logic [3:0]  busStrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_type_i (instType),
        .unsigned_i  (uns),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .read_data_o (readData),
        .exception_o (exc),
        .stall_o     (stall),
        .bus_valid_o (busValid),
        .bus_ready_i (busReady),
        .bus_we_o    (busWe),
        .bus_addr_o  (busAddr),
        .bus_wdata_o (busWdata),
        .bus_strb_o  (busStrb),
        .bus_rvalid_i(busRvalid),
        .bus_rerr_i  (busRerr),
        .bus_rdata_i (busRdata)
    );

    typedef struct {
        logic [3:0]  instType;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rerr;
        logic        immediate;
        logic [31:0] expRead;
        logic [31:0] expExc;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        logic        expWe;
    } vecT;

    localparam int NumVec = 14;
    vecT vecs[NumVec];

    function automatic vecT mk(input logic [3:0] t, input logic u, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input logic re,
                               input logic imm, input logic [31:0] er, input logic [31:0] ee,
                               input logic [31:0] ea, input logic [31:0] ew,
                               input logic [3:0] es, input logic we);
        vecT v;
        v.instType = t;  v.uns = u;     v.addr = a;     v.wdata = wd;
        v.rdata = rd;    v.rerr = re;   v.immediate = imm;
        v.expRead = er;  v.expExc = ee; v.expAddr = ea; v.expWdata = ew;
        v.expStrb = es;  v.expWe = we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setNoop();
        instType = 4'b0000; uns = 1'b0; addr = '0; wdata = '0;
    endtask

    // Entered and left just after a rising edge with the bridge idle.
    task automatic doAccess(input int idx, input vecT v);
        instType = v.instType; uns = v.uns; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        if (v.immediate) begin
            check($sformatf("v%0d_exc", idx), exc, v.expExc);
            check($sformatf("v%0d_stall", idx), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_novalid", idx), {31'b0, busValid}, 32'd0);
            setNoop();
            return;
        end
        check($sformatf("v%0d_stall_idle", idx), {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_valid", idx), {31'b0, busValid}, 32'd1);
        check($sformatf("v%0d_stall_req", idx), {31'b0, stall}, 32'd1);
        check($sformatf("v%0d_addr", idx), busAddr, v.expAddr);
        check($sformatf("v%0d_wdata", idx), busWdata, v.expWdata);
        check($sformatf("v%0d_strb", idx), {28'b0, busStrb}, {28'b0, v.expStrb});
        check($sformatf("v%0d_we", idx), {31'b0, busWe}, {31'b0, v.expWe});
        busReady = 1'b1;
        @(posedge clk); #1;
        busReady = 1'b0;
        busRvalid = 1'b1; busRdata = v.rdata; busRerr = v.rerr;
        @(negedge clk);
        check($sformatf("v%0d_stall_resp", idx), {31'b0, stall}, 32'd1);
        check($sformatf("v%0d_valid_resp", idx), {31'b0, busValid}, 32'd0);
        @(posedge clk); #1;
        busRvalid = 1'b0; busRerr = 1'b0; busRdata = '0;
        @(negedge clk);
        check($sformatf("v%0d_stall_done", idx), {31'b0, stall}, 32'd0);
        check($sformatf("v%0d_read", idx), readData, v.expRead);
        check($sformatf("v%0d_exc", idx), exc, v.expExc);
        @(posedge clk); #1;
        setNoop();
    endtask

    initial begin
        int  validCnt;
        bit  doneSeen;

        vecs[0]  = mk(4'b1010, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[1]  = mk(4'b1000, 0, 32'h103, 0, 32'h80FF0000, 0, 0, 32'hFFFFFF80, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[2]  = mk(4'b1000, 1, 32'h103, 0, 32'h80FF0000, 0, 0, 32'h00000080, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[3]  = mk(4'b1001, 0, 32'h102, 0, 32'h80FF0000, 0, 0, 32'hFFFF80FF, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[4]  = mk(4'b1001, 1, 32'h102, 0, 32'h80FF0000, 0, 0, 32'h000080FF, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[5]  = mk(4'b1000, 0, 32'h101, 0, 32'h00007F00, 0, 0, 32'h0000007F, 0,
                      32'h100, 0, 4'b0000, 0);
        vecs[6]  = mk(4'b0100, 0, 32'h201, 32'h000000AB, 0, 0, 0, 0, 0,
                      32'h200, 32'hABABABAB, 4'b0010, 1);
        vecs[7]  = mk(4'b0101, 0, 32'h202, 32'hFFFF1234, 0, 0, 0, 0, 0,
                      32'h200, 32'h12341234, 4'b1100, 1);
        vecs[8]  = mk(4'b0110, 0, 32'h204, 32'hCAFEF00D, 0, 0, 0, 0, 0,
                      32'h204, 32'hCAFEF00D, 4'b1111, 1);
        vecs[9]  = mk(4'b0110, 0, 32'h208, 32'h11223344, 0, 1, 0, 0, 32'd7,
                      32'h208, 32'h11223344, 4'b1111, 1);
        vecs[10] = mk(4'b1010, 0, 32'h102, 0, 0, 0, 1, 0, 32'd4, 0, 0, 4'b0000, 0);
        vecs[11] = mk(4'b0101, 0, 32'h201, 0, 0, 0, 1, 0, 32'd6, 0, 0, 4'b0000, 0);
        vecs[12] = mk(4'b1110, 0, 32'h101, 0, 0, 0, 1, 0, 32'd0, 0, 0, 4'b0000, 0);
        vecs[13] = mk(4'b1011, 0, 32'h100, 0, 0, 0, 1, 0, 32'd0, 0, 0, 4'b0000, 0);

        rst_n = 1'b0;
        setNoop();
        busReady = 1'b0; busRvalid = 1'b0; busRerr = 1'b0; busRdata = '0;
        #12;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_valid", {31'b0, busValid}, 32'd0);
        check("rst_exc", exc, 32'd0);
        check("rst_read", readData, 32'd0);
        check("rst_addr", busAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NumVec; i++) doAccess(i, vecs[i]);

        // Ready never arrives: request held 16 cycles, then a load fault.
        instType = 4'b1010; addr = 32'h300;
        validCnt = 0;
        doneSeen = 1'b0;
        for (int i = 0; i < 40 && !doneSeen; i++) begin
            @(negedge clk);
            if (busValid) validCnt++;
            if (i > 0 && !stall) doneSeen = 1'b1;
        end
        check("to_done", {31'b0, doneSeen}, 32'd1);
        check("to_valid_cycles", validCnt, 32'd16);
        check("to_exc", exc, 32'd5);
        check("to_valid_drop", {31'b0, busValid}, 32'd0);
        @(posedge clk); #1;
        setNoop();

        // Reset while waiting for a response.
        instType = 4'b1010; addr = 32'h400;
        @(posedge clk); #1;
        busReady = 1'b1;
        @(posedge clk); #1;
        busReady = 1'b0;
        @(negedge clk);
        check("rr_stall_resp", {31'b0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rr_stall", {31'b0, stall}, 32'd0);
        check("rr_valid", {31'b0, busValid}, 32'd0);
        check("rr_exc", exc, 32'd0);
        check("rr_read", readData, 32'd0);
        check("rr_addr", busAddr, 32'd0);
        check("rr_strb", {28'b0, busStrb}, 32'd0);
        check("rr_we", {31'b0, busWe}, 32'd0);
        setNoop();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        busRvalid = 1'b1; busRdata = 32'h12345678;
        @(negedge clk);
        check("late_stall", {31'b0, stall}, 32'd0);
        check("late_read", readData, 32'd0);
        @(posedge clk); #1;
        busRvalid = 1'b0; busRdata = '0;
        @(negedge clk);
        check("late_read2", readData, 32'd0);
        check("late_exc", exc, 32'd0);
        @(posedge clk); #1;
        doAccess(100, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
